// File: rtl/psum_requant.sv
// psum_requant: accumulates MAC partial sums per pixel, adds bias, requantizes to WQ bits.
// Final psum -> FIFO head in 3 edges; no upstream backpressure, a push on a full FIFO is dropped and flagged.
module psum_requant #(
  parameter int WI    = 8,
  parameter int N     = 16,
  parameter int WA    = 2*WI+$clog2(N)+2,
  parameter int WACC  = 32,
  parameter int WQ    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic signed [WA-1:0]   psum_i,
  input  logic                   psum_vld_i,
  input  logic                   clr_i,
  input  logic [7:0]             cfg_npass,
  input  logic signed [WACC-1:0] cfg_bias,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu,
  output logic [WQ-1:0]          q_o,
  output logic                   q_vld_o,
  input  logic                   q_rdy_i,
  output logic                   ovf_o,
  output logic [7:0]             pass_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [WACC:0] C_UMAX = (WACC+1)'((1 << WQ) - 1);
  localparam logic signed [WACC:0] C_SMAX = (WACC+1)'((1 << (WQ-1)) - 1);
  localparam logic signed [WACC:0] C_SMIN = (WACC+1)'(-(1 << (WQ-1)));

  logic [7:0]            r_pass, r_npass;
  logic [WACC-1:0]       r_acc, r_bias;
  logic [4:0]            r_shift, r_fin_shift;
  logic                  r_relu, r_fin_relu;
  logic signed [WACC-1:0] r_fin;
  logic                  r_fin_vld, r_q_vld, r_s3_vld;
  logic [WQ-1:0]         r_q, r_s3_dat;
  logic [WQ-1:0]         r_mem [DEPTH];
  logic [AW:0]           r_wp, r_rp;
  logic                  r_ovf;

  logic                  w_first, w_last, w_relu;
  logic [7:0]            w_npass;
  logic [4:0]            w_shift;
  logic [WACC-1:0]       w_bias, w_psum, w_next;
  logic signed [WACC:0]  w_rnd, w_sum, w_sh;
  logic [WQ-1:0]         w_q;
  logic [AW:0]           w_cnt;
  logic                  w_empty, w_full, w_pop, w_push;

  // Config is taken live on the first pass of a group, otherwise from the latched copy.
  always_comb begin
    w_first = (r_pass == 8'd0);
    w_npass = r_npass;
    w_bias  = r_bias;
    w_shift = r_shift;
    w_relu  = r_relu;
    if (w_first) begin
      w_npass = (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
      w_bias  = cfg_bias;
      w_shift = cfg_shift;
      w_relu  = cfg_relu;
    end
    w_last = (r_pass == w_npass - 8'd1);
    w_psum = {{(WACC-WA){psum_i[WA-1]}}, psum_i};
    w_next = (w_first ? w_bias : r_acc) + w_psum;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pass      <= '0;
      r_acc       <= '0;
      r_npass     <= 8'd1;
      r_bias      <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_fin       <= '0;
      r_fin_vld   <= 1'b0;
      r_fin_shift <= '0;
      r_fin_relu  <= 1'b0;
    end else if (clr_i) begin
      r_pass    <= '0;
      r_acc     <= '0;
      r_fin_vld <= 1'b0;
    end else begin
      r_fin_vld <= psum_vld_i & w_last;
      if (psum_vld_i) begin
        r_acc <= w_next;
        if (w_first) begin
          r_npass <= w_npass;
          r_bias  <= w_bias;
          r_shift <= w_shift;
          r_relu  <= w_relu;
        end
        if (w_last) begin
          r_pass      <= '0;
          r_fin       <= w_next;
          r_fin_shift <= w_shift;
          r_fin_relu  <= w_relu;
        end else begin
          r_pass <= r_pass + 8'd1;
        end
      end
    end
  end

  // One guard bit keeps the rounding add from wrapping before the shift.
  always_comb begin
    w_rnd = '0;
    if (r_fin_shift != 5'd0) w_rnd = (WACC+1)'(1) << (r_fin_shift - 5'd1);
    w_sum = $signed({r_fin[WACC-1], r_fin}) + w_rnd;
    w_sh  = w_sum >>> r_fin_shift;
    w_q   = w_sh[WQ-1:0];
    if (r_fin_relu) begin
      if (w_sh[WACC])          w_q = '0;
      else if (w_sh > C_UMAX)  w_q = '1;
    end else begin
      if (w_sh > C_SMAX)       w_q = C_SMAX[WQ-1:0];
      else if (w_sh < C_SMIN)  w_q = C_SMIN[WQ-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q      <= '0;
      r_q_vld  <= 1'b0;
      r_s3_dat <= '0;
      r_s3_vld <= 1'b0;
    end else begin
      r_q      <= w_q;
      r_q_vld  <= r_fin_vld & ~clr_i;
      r_s3_dat <= r_q;
      r_s3_vld <= r_q_vld & ~clr_i;
    end
  end

  // A pop frees the head slot in the same edge, so a push into a full FIFO still lands.
  always_comb begin
    w_cnt   = r_wp - r_rp;
    w_empty = (r_wp == r_rp);
    w_full  = (w_cnt == (AW+1)'(DEPTH));
    w_pop   = ~w_empty & q_rdy_i;
    w_push  = r_s3_vld & (~w_full | w_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (r_s3_vld & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push & ~clr_i) r_mem[r_wp[AW-1:0]] <= r_s3_dat;
  end

  assign q_o        = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign q_vld_o    = ~w_empty;
  assign ovf_o      = r_ovf;
  assign pass_cnt_o = r_pass;

endmodule

// File: tb/tb_psum_requant.sv
// Randomized and directed bench for psum_requant against a queue-based reference model.
module tb_psum_requant;
  localparam int WA = 22, WACC = 32, WQ = 8, DEPTH = 4;

  logic                   clk = 1'b0, rstn = 1'b0;
  logic signed [WA-1:0]   psum_i;
  logic                   psum_vld_i, clr_i, cfg_relu, q_rdy_i;
  logic [7:0]             cfg_npass;
  logic signed [WACC-1:0] cfg_bias;
  logic [4:0]             cfg_shift;
  logic [WQ-1:0]          q_o;
  logic                   q_vld_o, ovf_o;
  logic [7:0]             pass_cnt_o;

  psum_requant dut (
    .clk(clk), .rstn(rstn), .psum_i(psum_i), .psum_vld_i(psum_vld_i), .clr_i(clr_i),
    .cfg_npass(cfg_npass), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .q_o(q_o), .q_vld_o(q_vld_o), .q_rdy_i(q_rdy_i), .ovf_o(ovf_o), .pass_cnt_o(pass_cnt_o)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;

  task automatic chk(string tag, longint got, longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Reference: group sum in plain 32-bit ints, results due 3 edges after the final psum.
  typedef struct { int due; logic [7:0] val; } pend_t;
  pend_t      m_pend[$];
  logic [7:0] m_fifo[$];
  int         m_cyc = 0, m_cnt = 0, m_npass = 1, m_sum = 0, m_shift = 0;
  bit         m_relu = 0, m_ovf = 0, m_pop, m_have;

  function automatic logic [7:0] quant(int fin, int sh, bit relu);
    longint r;
    r = longint'(fin);
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    if (relu) begin
      if (r < 0) r = 0;
      if (r > 255) r = 255;
    end else begin
      if (r > 127) r = 127;
      if (r < -128) r = -128;
    end
    return r[7:0];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0; m_ovf = 0;
      m_pend.delete(); m_fifo.delete();
    end else begin
      m_cyc++;
      if (clr_i) begin
        m_cnt = 0; m_ovf = 0;
        m_pend.delete(); m_fifo.delete();
      end else begin
        m_pop  = (m_fifo.size() != 0) && q_rdy_i;
        m_have = (m_pend.size() != 0) && (m_pend[0].due == m_cyc);
        if (m_pop) void'(m_fifo.pop_front());
        if (m_have) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend[0].val);
          else m_ovf = 1;
          void'(m_pend.pop_front());
        end
        if (psum_vld_i) begin
          if (m_cnt == 0) begin
            m_npass = (cfg_npass == 0) ? 1 : int'(cfg_npass);
            m_sum   = cfg_bias;
            m_shift = int'(cfg_shift);
            m_relu  = cfg_relu;
          end
          m_sum = m_sum + int'(psum_i);
          m_cnt++;
          if (m_cnt == m_npass) begin
            m_cnt = 0;
            m_pend.push_back('{due: m_cyc + 3, val: quant(m_sum, m_shift, m_relu)});
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("q_vld", q_vld_o, m_fifo.size() != 0);
    chk("q", q_o, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
    chk("ovf", ovf_o, m_ovf);
    chk("pass_cnt", pass_cnt_o, m_cnt);
  end

  task automatic cyc(bit v, int d);
    psum_vld_i = v;
    psum_i     = WA'(d);
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    psum_vld_i = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_vld(string tag);
    int n = 0;
    psum_vld_i = 0;
    while (!q_vld_o && n < 12) begin @(posedge clk); #1; n++; end
    if (!q_vld_o) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic one(int v, logic [7:0] exp, string tag);
    cyc(1, v);
    wait_vld(tag);
    chk(tag, q_o, exp);
    idle(2);
  endtask

  task automatic set_cfg(int np, int bias, int sh, bit relu);
    cfg_npass = 8'(np); cfg_bias = bias; cfg_shift = 5'(sh); cfg_relu = relu;
  endtask

  initial begin
    psum_i = '0; psum_vld_i = 0; clr_i = 0; q_rdy_i = 1;
    set_cfg(1, 0, 0, 0);
    #1;
    chk("rst_q", q_o, 0); chk("rst_vld", q_vld_o, 0);
    chk("rst_ovf", ovf_o, 0); chk("rst_pcnt", pass_cnt_o, 0);
    #12 rstn = 1;
    @(posedge clk); #1;

    // back-to-back npass=1 results, exact latency
    cyc(1, 100); cyc(1, -5);
    psum_vld_i = 0;
    @(posedge clk); #1; chk("t1_lat", q_vld_o, 0);
    @(posedge clk); #1; chk("t1_vld0", q_vld_o, 1); chk("t1_q0", q_o, 8'h64);
    @(posedge clk); #1; chk("t1_vld1", q_vld_o, 1); chk("t1_q1", q_o, 8'hFB);
    @(posedge clk); #1; chk("t1_empty", q_vld_o, 0);

    // four-pass group with bias, rounding and relu
    set_cfg(4, 10, 2, 1);
    cyc(1, 100); chk("t2_pc1", pass_cnt_o, 1);
    cyc(1, 200); chk("t2_pc2", pass_cnt_o, 2);
    cyc(1, -50); chk("t2_pc3", pass_cnt_o, 3);
    cyc(1, 30);  chk("t2_pc0", pass_cnt_o, 0);
    wait_vld("t2"); chk("t2_q", q_o, 8'h49);
    idle(3);

    // saturation and rounding corners
    set_cfg(1, 0, 0, 0);
    one(1000, 8'h7F, "t3_smax"); one(-1000, 8'h80, "t3_smin");
    cfg_relu = 1;
    one(-7, 8'h00, "t3_rneg"); one(300, 8'hFF, "t3_rmax");
    cfg_relu = 0; cfg_shift = 1;
    one(-3, 8'hFF, "t3_rnd");
    cfg_shift = 0;

    // overflow on a full FIFO, then in-order drain
    q_rdy_i = 0;
    for (int k = 1; k <= 6; k++) cyc(1, k);
    idle(6);
    chk("t4_ovf", ovf_o, 1); chk("t4_head", q_o, 1);
    q_rdy_i = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_pop", q_o, k);
      @(posedge clk); #1;
    end
    chk("t4_drained", q_vld_o, 0);

    // full FIFO: push and pop on the same edge must not drop
    clr_i = 1; idle(1); clr_i = 0;
    q_rdy_i = 0;
    for (int k = 1; k <= 5; k++) cyc(1, k);
    idle(2);
    q_rdy_i = 1;
    idle(8);
    chk("t4_noovf", ovf_o, 0);

    // clear mid-group, then latched shift immune to mid-group changes
    set_cfg(4, 0, 0, 0);
    cyc(1, 8); cyc(1, 8);
    clr_i = 1; idle(1); clr_i = 0;
    chk("t5_pc", pass_cnt_o, 0); chk("t5_ovf", ovf_o, 0);
    cyc(1, 8); cyc(1, 8);
    cfg_shift = 3;
    cyc(1, 8); cyc(1, 8);
    cfg_shift = 0;
    wait_vld("t5"); chk("t5_q", q_o, 32);
    idle(3);

    // asynchronous reset with FIFO entries and a half group
    q_rdy_i = 0;
    set_cfg(1, 0, 0, 0);
    cyc(1, 1); cyc(1, 2); cyc(1, 3);
    idle(4);
    chk("t6_pre", q_vld_o, 1);
    cfg_npass = 2;
    cyc(1, 50);
    psum_vld_i = 0;
    #2 rstn = 0;
    #1 chk("t6_vld", q_vld_o, 0); chk("t6_q", q_o, 0); chk("t6_pc", pass_cnt_o, 0);
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;
    q_rdy_i = 1;
    cyc(1, 5); cyc(1, 6);
    wait_vld("t6"); chk("t6_q2", q_o, 11);
    idle(3);

    // random traffic with random config, stalls and occasional clears
    for (int i = 0; i < 2000; i++) begin
      cfg_npass = 8'($urandom_range(0, 5));
      cfg_bias  = $signed($urandom) >>> $urandom_range(8, 30);
      cfg_shift = 5'(($urandom % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10));
      cfg_relu  = 1'($urandom % 2);
      q_rdy_i   = ($urandom % 3) != 0;
      clr_i     = ($urandom % 64) == 0;
      psum_i    = ($urandom % 2) ? WA'($urandom) : WA'(int'($urandom_range(0, 600)) - 300);
      psum_vld_i = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    clr_i = 0; q_rdy_i = 1;
    idle(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/psum_requant.md
Name: psum_requant

Overview:
Sink side of the MAC result interface. Takes the signed partial sums and valid strobe produced by the 16-lane MAC tree. It accumulates a configurable number of passes per output pixel, adds a bias, and requantizes the total to 8 bits with round-half-up, optional ReLU and saturation. Results go through a small show-ahead FIFO with a valid/ready handshake toward the output buffer writer. The MAC has no backpressure input, so the FIFO absorbs stalls and flags any loss.

Parameters:
WI, 8, MAC operand width
N, 16, MAC lanes
WA, 2*WI+$clog2(N)+2 (=22), signed partial-sum input width
WACC, 32, accumulator width
WQ, 8, output width
DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
psum_i  in  WA  signed partial sum from MAC
psum_vld_i  in  1  partial sum valid, one-cycle strobe per psum
clr_i  in  1  synchronous clear of accumulation, pipeline, FIFO and ovf_o
cfg_npass  in  8  passes per pixel; 0 treated as 1
cfg_bias  in  WACC  signed bias
cfg_shift  in  5  arithmetic right shift, 0..31
cfg_relu  in  1  1 = ReLU, unsigned [0,255] saturation; 0 = signed [-128,127]
q_o  out  WQ  quantized result (FIFO head)
q_vld_o  out  1  FIFO non-empty
q_rdy_i  in  1  consumer ready
ovf_o  out  1  sticky: result dropped on full FIFO
pass_cnt_o  out  8  current pass index within group

Behaviour:
- Reset (rstn low, async): acc=0, pass count=0, all stage valids=0, FIFO empty, q_o=0, q_vld_o=0, ovf_o=0, pass_cnt_o=0.
- Config capture: on a psum_vld_i edge with pass count 0, latch npass_eff, bias, shift and relu. All later stages use the latched copies; changing cfg mid-group has no effect on that group.
- Accumulation: each psum is sign-extended to WACC.
  - First pass: acc <= bias + psum.
  - Other passes: acc <= acc + psum.
  - Addition wraps in two's complement; no overflow detection.
- Pass count increments per psum. On the final pass (count == npass_eff-1):
  - count <= 0.
  - fin <= (first ? bias : acc) + psum.
  - fin_vld <= 1.
- Stage 2 (from fin, fin_vld):
  - r = (fin + (shift ? 1<<(shift-1) : 0)) >>> shift, arithmetic.
  - If relu: r<0 -> 0, r>255 -> 255.
  - Else: clamp to [-128,127].
  - Result register and q_vld stage <= fin_vld.
- Stage 3: the stage-2 result is pushed into the FIFO.
- Latency: the final psum sampled at edge k gives q_o/q_vld_o valid after edge k+3 when the FIFO is empty.
- Throughput: one psum per cycle, back to back, including npass=1. Groups chain with no bubble.
- FIFO:
  - Show-ahead: q_o = head entry whenever q_vld_o=1; q_o is 0 when empty.
  - Pop on q_vld_o & q_rdy_i.
  - Push and pop in the same cycle are both honoured, including when full (occupancy unchanged).
  - Push while full without pop: result dropped, ovf_o <= 1, held until clr_i or reset.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo DEPTH.
- clr_i: takes priority over psum_vld_i and push in the same cycle. Clears:
  - pass count, acc, fin_vld and stage-2 valid;
  - FIFO, ovf_o.
  - In-flight results are discarded.
- Reset mid-operation: same effect as clr_i but immediate (async). q_vld_o drops without waiting for a clock.
- pass_cnt_o = pass count register.

Test Plan:
1. npass=1, bias=0, shift=0, relu=0, q_rdy_i=1; psum 100 then -5 on consecutive cycles -> q_o=0x64 then 0xFB, each 3 edges after input, q_vld_o high 2 cycles.
2. npass=4, bias=10, shift=2, relu=1; psums 100,200,-50,30 -> sum 290, (290+2)>>>2 = 73 -> single q_o=0x49; pass_cnt_o steps 1,2,3,0.
3. npass=1, shift=0:
   - relu=0: psum 1000 -> 0x7F; psum -1000 -> 0x80.
   - relu=1: psum -7 -> 0x00; psum 300 -> 0xFF.
   - shift=1, relu=0: psum -3 -> (-2)>>>1 = -1 -> 0xFF.
4. DEPTH=4, q_rdy_i=0, six npass=1 results 1..6:
   - FIFO holds 1,2,3,4; ovf_o rises when 5 arrives.
   - Then q_rdy_i=1 -> pops 1,2,3,4 in order, then q_vld_o=0.
   - Full FIFO with simultaneous push/pop -> no drop, ovf_o unchanged.
5. npass=4, clr_i after 2 psums -> pass_cnt_o=0, ovf_o=0. Next 4 psums of 8 each, bias 0, shift 0 -> q_o=32, no residue from the cleared passes.
   - Change cfg_shift mid-group -> result still uses the shift latched at pass 0.
6. rstn low with 3 FIFO entries and a group half-accumulated -> q_vld_o=0 and q_o=0 asynchronously.
   - After release, a fresh npass=2 group 5,6 -> q_o=11.
